// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_pkg;

    localparam int NUM_REQ_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        GAP   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // Index width that stays legal for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches from last_grant+1 upward, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] gnt_onehot,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               any_req
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        found      = 1'b0;
        cand       = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(last_grant) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                gnt_onehot[cand] = 1'b1;
                gnt_idx          = cand;
                found            = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NUM_REQ byte requesters with round-robin fairness
// and a fixed IDLE/SEND/GAP/DRAIN handshake per byte.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int  NUM_REQ = NUM_REQ_DEF,
    parameter int  CNT_W   = 16,
    localparam int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_valid,
    output logic [7:0]           tx_data,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic [IDX_W-1:0]     grant_id,
    output logic [CNT_W-1:0]     sent_count
);

    state_t             state, state_next;
    logic [IDX_W-1:0]   last_grant, gnt_idx;
    logic [NUM_REQ-1:0] gnt_onehot;
    logic               any_req, accept;
    logic [7:0]         sel_data;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
        .req        (req_valid),
        .last_grant (last_grant),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any_req    (any_req)
    );

    always_comb begin
        sel_data = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_onehot[i]) sel_data = req_data[8*i +: 8];
        end
    end

    // req_ready is combinational in IDLE, so it must be masked while reset is held.
    always_comb begin
        state_next = state;
        req_ready  = '0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    accept     = 1'b1;
                    req_ready  = gnt_onehot & {NUM_REQ{rst_n}};
                    state_next = SEND;
                end
            end
            SEND:    if (tx_ready) state_next = GAP;
            GAP:     state_next = DRAIN;
            DRAIN:   if (tx_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data    <= 8'h00;
            grant_id   <= '0;
            last_grant <= IDX_W'(NUM_REQ - 1);
            sent_count <= '0;
        end else begin
            if (accept) begin
                tx_data    <= sel_data;
                grant_id   <= gnt_idx;
                last_grant <= gnt_idx;
            end
            if (state == SEND && tx_ready) sent_count <= sent_count + 1'b1;
        end
    end

    assign tx_valid = (state == SEND);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized
// traffic checked against a queue-based round-robin reference model.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int CW = 10;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [8*N-1:0]  req_data;
    logic [N-1:0]    req_ready;
    logic            tx_valid;
    logic [7:0]      tx_data;
    logic            tx_ready;
    logic            busy;
    logic [1:0]      grant_id;
    logic [CW-1:0]   sent_count;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx_arbiter #(.NUM_REQ(N), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .grant_id   (grant_id),
        .sent_count (sent_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        tx_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '1;
        req_data  = 32'h13121110;
        tx_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (req_ready !== 4'b0000) begin n_errors++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
        n_checks++; if (tx_valid !== 1'b0) begin n_errors++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
        n_checks++; if (tx_data !== 8'h00) begin n_errors++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (grant_id !== 2'd0) begin n_errors++; $display("FAIL reset_grant_id got=%0d exp=0", grant_id); end
        n_checks++; if (sent_count !== '0) begin n_errors++; $display("FAIL reset_sent_count got=%0d exp=0", sent_count); end
        rst_n = 1'b1;
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_errors++; $display("FAIL reset_first_priority got=%b exp=0001", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 4'b0001;
        req_data  = {24'h0, 8'h41};
        tx_ready  = 1'b1;
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_errors++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
        cyc();
        req_valid = '0;
        #1;
        n_checks++; if (tx_valid !== 1'b1) begin n_errors++; $display("FAIL single_tx_valid got=%b exp=1", tx_valid); end
        n_checks++; if (tx_data !== 8'h41) begin n_errors++; $display("FAIL single_tx_data got=%h exp=41", tx_data); end
        n_checks++; if (req_ready !== 4'b0000) begin n_errors++; $display("FAIL single_ready_once got=%b exp=0000", req_ready); end
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL single_busy got=%b exp=1", busy); end
        cyc();
        #1;
        n_checks++; if (tx_valid !== 1'b0) begin n_errors++; $display("FAIL single_gap_valid got=%b exp=0", tx_valid); end
        n_checks++; if (sent_count !== CW'(1)) begin n_errors++; $display("FAIL single_count got=%0d exp=1", sent_count); end
        cyc();
        #1;
        n_checks++; if (tx_valid !== 1'b0 || busy !== 1'b1) begin n_errors++; $display("FAIL single_drain got valid=%b busy=%b exp valid=0 busy=1", tx_valid, busy); end
        cyc();
        #1;
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
        n_checks++; if (tx_data !== 8'h41) begin n_errors++; $display("FAIL single_data_hold got=%h exp=41", tx_data); end
    endtask

    task automatic test_order();
        logic [N-1:0] pend;
        logic [7:0]   got_data[$];
        int           got_id[$];
        do_reset();
        pend     = 4'b1111;
        req_data = 32'h13121110;
        tx_ready = 1'b1;
        for (int c = 0; c < 60 && got_data.size() < 4; c++) begin
            req_valid = pend;
            #1;
            pend = pend & ~req_ready;
            if (tx_valid === 1'b1 && tx_ready) begin
                got_data.push_back(tx_data);
                got_id.push_back(int'(grant_id));
            end
            cyc();
        end
        req_valid = '0;
        n_checks++; if (got_data.size() != 4) begin n_errors++; $display("FAIL order_count got=%0d exp=4", got_data.size()); end
        for (int i = 0; i < 4 && i < got_data.size(); i++) begin
            n_checks++; if (got_data[i] !== 8'(8'h10 + i)) begin n_errors++; $display("FAIL order_data[%0d] got=%h exp=%h", i, got_data[i], 8'h10 + i); end
            n_checks++; if (got_id[i] != i) begin n_errors++; $display("FAIL order_grant[%0d] got=%0d exp=%0d", i, got_id[i], i); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        tx_ready  = 1'b0;
        req_valid = 4'b0100;
        req_data  = 32'h335A2211;
        cyc();
        req_valid = 4'b1011;
        #1;
        for (int i = 0; i < 20; i++) begin
            n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h5A) begin n_errors++; $display("FAIL stall_hold[%0d] got valid=%b data=%h exp valid=1 data=5a", i, tx_valid, tx_data); end
            n_checks++; if (req_ready !== 4'b0000 || sent_count !== '0) begin n_errors++; $display("FAIL stall_quiet[%0d] got ready=%b count=%0d exp ready=0000 count=0", i, req_ready, sent_count); end
            if (i < 19) cyc();
        end
        cyc();
        tx_ready = 1'b1;
        #1;
        n_checks++; if (tx_valid !== 1'b1) begin n_errors++; $display("FAIL stall_release_valid got=%b exp=1", tx_valid); end
        cyc();
        req_valid = '0;
        #1;
        n_checks++; if (sent_count !== CW'(1) || tx_valid !== 1'b0) begin n_errors++; $display("FAIL stall_after got count=%0d valid=%b exp count=1 valid=0", sent_count, tx_valid); end
        repeat (3) cyc();
    endtask

    task automatic test_alternate();
        int seq[$];
        int last_pulse;
        do_reset();
        req_valid  = 4'b1010;
        req_data   = 32'hB3000A10;
        tx_ready   = 1'b1;
        last_pulse = -100;
        for (int c = 0; c < 80 && seq.size() < 6; c++) begin
            #1;
            for (int i = 0; i < N; i++) if (req_ready[i]) seq.push_back(i);
            if (req_ready !== 4'b0000) begin
                n_checks++; if (c - last_pulse < 4) begin n_errors++; $display("FAIL alt_spacing got=%0d exp>=4", c - last_pulse); end
                last_pulse = c;
            end
            cyc();
        end
        req_valid = '0;
        n_checks++; if (seq.size() != 6) begin n_errors++; $display("FAIL alt_count got=%0d exp=6", seq.size()); end
        for (int i = 0; i < seq.size(); i++) begin
            n_checks++; if (seq[i] != ((i % 2 == 0) ? 1 : 3)) begin n_errors++; $display("FAIL alt_grant[%0d] got=%0d exp=%0d", i, seq[i], (i % 2 == 0) ? 1 : 3); end
        end
    endtask

    task automatic test_wrap();
        int  xfers;
        int  target;
        bit  done;
        do_reset();
        req_valid = 4'b0001;
        req_data  = {24'h0, 8'hC3};
        tx_ready  = 1'b1;
        xfers     = 0;
        target    = (1 << CW) - 1;
        done      = 1'b0;
        for (int c = 0; c < 8 * (1 << CW) && !done; c++) begin
            #1;
            if (tx_valid === 1'b1) begin
                xfers++;
                if (xfers == target || xfers == target + 1) begin
                    cyc();
                    #1;
                    if (xfers == target) begin
                        n_checks++; if (sent_count !== CW'(target)) begin n_errors++; $display("FAIL wrap_full got=%0d exp=%0d", sent_count, target); end
                    end else begin
                        n_checks++; if (sent_count !== '0) begin n_errors++; $display("FAIL wrap_zero got=%0d exp=0", sent_count); end
                        done = 1'b1;
                    end
                end
            end
            if (!done) cyc();
        end
        req_valid = '0;
        n_checks++; if (!done) begin n_errors++; $display("FAIL wrap_timeout got=%0d transfers exp=%0d", xfers, target + 1); end
    endtask

    task automatic test_reset_mid_send();
        do_reset();
        tx_ready  = 1'b0;
        req_valid = 4'b0001;
        req_data  = 32'h44332277;
        cyc();
        req_valid = '0;
        #1;
        n_checks++; if (tx_valid !== 1'b1) begin n_errors++; $display("FAIL midrst_in_send got=%b exp=1", tx_valid); end
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL midrst_async got valid=%b busy=%b exp 0 0", tx_valid, busy); end
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        req_valid = 4'b0110;
        tx_ready  = 1'b1;
        #1;
        n_checks++; if (sent_count !== '0) begin n_errors++; $display("FAIL midrst_count got=%0d exp=0", sent_count); end
        n_checks++; if (req_ready !== 4'b0010) begin n_errors++; $display("FAIL midrst_first_grant got=%b exp=0010", req_ready); end
        cyc();
        req_valid = 4'b0100;
        #1;
        n_checks++; if (tx_data !== 8'h22 || grant_id !== 2'd1) begin n_errors++; $display("FAIL midrst_no_retry got data=%h id=%0d exp data=22 id=1", tx_data, grant_id); end
        req_valid = '0;
        repeat (4) cyc();
    endtask

    task automatic test_random(input int cycles);
        int           model_lg, model_cnt, last_pulse, win;
        logic [N-1:0] pend, exp_oh;
        logic [7:0]   pend_data[N];
        logic [7:0]   exp_data[$];
        int           exp_id[$];
        do_reset();
        model_lg   = N - 1;
        model_cnt  = 0;
        last_pulse = -100;
        pend       = '0;
        for (int i = 0; i < N; i++) pend_data[i] = 8'h00;
        for (int c = 0; c < cycles + 400; c++) begin
            if (c < cycles) begin
                for (int i = 0; i < N; i++) begin
                    if (!pend[i] && $urandom_range(0, 2) == 0) begin
                        pend[i]      = 1'b1;
                        pend_data[i] = 8'($urandom);
                    end
                end
            end
            tx_ready  = ($urandom_range(0, 3) != 0);
            req_valid = pend;
            for (int i = 0; i < N; i++) req_data[8*i +: 8] = pend_data[i];
            #1;
            win = -1;
            for (int k = 1; k <= N; k++) begin
                int cand;
                cand = (model_lg + k) % N;
                if (win < 0 && pend[cand]) win = cand;
            end
            exp_oh = '0;
            if (win >= 0) exp_oh[win] = 1'b1;
            if (req_ready !== '0) begin
                n_checks++; if (req_ready !== exp_oh) begin n_errors++; $display("FAIL rand_winner got=%b exp=%b", req_ready, exp_oh); end
                n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rand_grant_busy got=%b exp=0", busy); end
                n_checks++; if (c - last_pulse < 4) begin n_errors++; $display("FAIL rand_spacing got=%0d exp>=4", c - last_pulse); end
                for (int i = 0; i < N; i++) begin
                    if (req_ready[i]) begin
                        exp_data.push_back(pend_data[i]);
                        exp_id.push_back(i);
                        pend[i]  = 1'b0;
                        model_lg = i;
                    end
                end
                last_pulse = c;
            end else if (busy === 1'b0 && pend != '0) begin
                n_checks++; n_errors++;
                $display("FAIL rand_idle_no_grant got=%b exp=%b", req_ready, exp_oh);
            end
            n_checks++; if (sent_count !== CW'(model_cnt)) begin n_errors++; $display("FAIL rand_count got=%0d exp=%0d", sent_count, model_cnt); end
            if (tx_valid === 1'b1) begin
                n_checks++;
                if (exp_data.size() == 0) begin
                    n_errors++; $display("FAIL rand_spurious_tx got data=%h exp=no byte", tx_data);
                end else begin
                    if (tx_data !== exp_data[0] || int'(grant_id) != exp_id[0]) begin
                        n_errors++; $display("FAIL rand_tx got data=%h id=%0d exp data=%h id=%0d", tx_data, grant_id, exp_data[0], exp_id[0]);
                    end
                    if (tx_ready) begin
                        void'(exp_data.pop_front());
                        void'(exp_id.pop_front());
                        model_cnt = (model_cnt + 1) % (1 << CW);
                    end
                end
            end
            if (c >= cycles && pend == '0 && exp_data.size() == 0 && busy === 1'b0) break;
            cyc();
        end
        req_valid = '0;
        n_checks++; if (pend != '0 || exp_data.size() != 0) begin n_errors++; $display("FAIL rand_drain got pend=%b outstanding=%0d exp 0 0", pend, exp_data.size()); end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        tx_ready  = 1'b0;
        test_reset();
        test_single();
        test_order();
        test_stall();
        test_alternate();
        test_reset_mid_send();
        test_random(3000);
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of byte requesters sharing one uart_tx.
REQ-002 Parameter CNT_W, default 16, width of the sent-byte counter.
REQ-003 Port clk  input  1  single system clock; all logic on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port req_valid  input  NUM_REQ  per-requester byte-pending flag.
REQ-006 Port req_data  input  8*NUM_REQ  packed bytes; requester i occupies bits [8i+7:8i].
REQ-007 Port req_ready  output  NUM_REQ  one-hot, one-cycle acceptance strobe per requester.
REQ-008 Port tx_valid  output  1  byte-offer strobe to uart_tx.
REQ-009 Port tx_data  output  8  byte presented to uart_tx.
REQ-010 Port tx_ready  input  1  uart_tx idle/accepting flag.
REQ-011 Port busy  output  1  high whenever state is not IDLE.
REQ-012 Port grant_id  output  clog2(NUM_REQ)  index of the requester currently owning the transmitter.
REQ-013 Port sent_count  output  CNT_W  count of bytes handed to uart_tx.

Function
REQ-014 The FSM SHALL have states IDLE, SEND, GAP and DRAIN.
REQ-015 In IDLE with any req_valid high, the block SHALL select one winner by round-robin, starting the search at last_grant+1 modulo NUM_REQ.
REQ-016 On selection, the block SHALL latch the winner's byte and index, pulse req_ready[winner] for exactly that cycle, update last_grant, and move to SEND on the next cycle.
REQ-017 In IDLE with no req_valid, the block SHALL stay in IDLE with all req_ready low.
REQ-018 Requesters SHALL hold req_valid and req_data stable until their req_ready pulse; after the pulse the block SHALL ignore that requester's data.
REQ-019 In SEND, tx_valid SHALL be 1 and tx_data SHALL be the latched byte; the cycle with tx_valid and tx_ready both high is the transfer.
REQ-020 On the transfer cycle, sent_count SHALL increment by 1, wrapping from all-ones to 0, and the state SHALL move to GAP.
REQ-021 GAP SHALL last exactly one cycle with tx_valid low, then move to DRAIN.
REQ-022 DRAIN SHALL hold tx_valid low until tx_ready is 1, then return to IDLE.
REQ-023 The minimum spacing between successive req_ready pulses SHALL be 4 cycles.
REQ-024 Outside SEND, tx_valid SHALL be 0; tx_data SHALL retain the last latched byte.
REQ-025 grant_id SHALL show the latched index from selection until the return to IDLE, and SHALL hold its value in IDLE.
REQ-026 A req_valid that rises while the block is not in IDLE SHALL wait; it is not lost and is not accepted early.
REQ-027 A requester whose req_valid stays high continuously SHALL be granted at most once per full rotation while the other requesters are valid, so no requester starves.

Reset
REQ-028 While rst_n is 0, the block SHALL force state=IDLE, tx_valid=0, tx_data=0, req_ready=0, busy=0, grant_id=0, sent_count=0, and last_grant=NUM_REQ-1, so requester 0 has first priority.
REQ-029 Reset asserted mid-SEND SHALL drop tx_valid asynchronously; the interrupted byte SHALL NOT be counted and SHALL NOT be retried.

Structure
REQ-030 The state enum and the default NUM_REQ SHALL live in the shared package uart_pkg.
REQ-031 Round-robin selection SHALL be a sub-module rr_arbiter, with inputs req and last_grant and outputs gnt_onehot, gnt_idx and any_req; it SHALL be purely combinational.
REQ-032 The top level SHALL instantiate this block between the requesters and uart_tx, driving uart_tx's tx_valid and tx_data.

Verification
REQ-033 Single request: req_valid=0001, data 8'h41, tx_ready=1 -> req_ready=0001 for one cycle; tx_valid high for 1 cycle with tx_data=8'h41; sent_count=1.
REQ-034 All four requesters valid, with data 8'h10/11/12/13, run from reset -> transmit order 8'h10, 11, 12, 13; grant_id sequence 0, 1, 2, 3.
REQ-035 tx_ready held at 0 for 20 cycles in SEND -> tx_valid and tx_data stay stable for those 20 cycles; no req_ready pulse and no count increment.
REQ-036 Requesters 1 and 3 continuously valid, last_grant=1 -> next grant is 3, then 1, alternating.
REQ-037 sent_count preloaded to 16'hFFFF via 65535 transfers, then one more transfer -> sent_count=0.
REQ-038 rst_n pulsed low during SEND -> tx_valid=0 within the same cycle; after release state=IDLE, sent_count=0, and the first grant goes to the lowest-index valid requester.
